// File: rtl/instruction_fetch_if.sv
// Bundles the instruction-memory request/response channel, the redirect
// input and the execute-side instruction handshake of the fetch stage.
interface instruction_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] pcNext;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_pc,
    output instr_valid, instruction, pc, pcNext,
    input  instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_pc,
    input  instr_valid, instruction, pc, pcNext,
    output instr_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues credit-limited word reads, pairs in-order
// responses with their addresses and buffers them for the execute stage.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input logic                 clk,
  input logic                 reset_n,
  instruction_fetch_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DepthW = (CW + 1)'(DEPTH);

  logic [31:0]   fetchPc_q, fetchPc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW-1:0] tagHead_q, tagHead_d, tagTail_q, tagTail_d;
  logic [31:0]   entryPc_q    [DEPTH];
  logic [31:0]   entryInstr_q [DEPTH];
  logic [31:0]   tag_q        [DEPTH];

  logic          reqValid, reqFire, respFire, popFire, pushEn, headValid;
  logic [CW:0]   credit;
  logic [31:0]   headPc;

  // Credit counts both buffered and outstanding words, so a response always finds room.
  assign credit    = {1'b0, inflight_q} + {1'b0, count_q};
  assign reqValid  = reset_n && !bus.redirect_valid && (credit < DepthW);
  assign reqFire   = reqValid && bus.imem_req_ready;
  assign respFire  = bus.imem_resp_valid;
  assign headValid = (count_q != '0);
  assign popFire   = headValid && bus.instr_ready;
  assign pushEn    = respFire && !bus.redirect_valid && (discard_q == '0);
  assign headPc    = entryPc_q[head_q];

  assign bus.imem_req_valid = reqValid;
  assign bus.imem_req_addr  = fetchPc_q;
  assign bus.instr_valid    = headValid;
  assign bus.instruction    = entryInstr_q[head_q];
  assign bus.pc             = headPc;
  assign bus.pcNext         = headPc + 32'd4;

  always_comb begin
    fetchPc_d  = fetchPc_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    tagHead_d  = tagHead_q;
    tagTail_d  = tagTail_q;

    if (reqFire) begin
      fetchPc_d = fetchPc_q + 32'd4;
      tagTail_d = tagTail_q + PW'(1);
    end
    if (respFire) begin
      tagHead_d = tagHead_q + PW'(1);
    end
    inflight_d = inflight_q + CW'(reqFire) - CW'(respFire);

    // Tags are never flushed: stale responses still retire their tag entry.
    if (bus.redirect_valid) begin
      fetchPc_d = bus.redirect_pc & ~32'd3;
      discard_d = inflight_q - CW'(respFire);
      count_d   = '0;
      head_d    = '0;
      tail_d    = '0;
    end else begin
      if (respFire && (discard_q != '0)) begin
        discard_d = discard_q - CW'(1);
      end
      if (pushEn) begin
        tail_d = tail_q + PW'(1);
      end
      if (popFire) begin
        head_d = head_q + PW'(1);
      end
      count_d = count_q + CW'(pushEn) - CW'(popFire);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetchPc_q  <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      tagHead_q  <= '0;
      tagTail_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entryPc_q[i]    <= '0;
        entryInstr_q[i] <= '0;
        tag_q[i]        <= '0;
      end
    end else begin
      fetchPc_q  <= fetchPc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      tagHead_q  <= tagHead_d;
      tagTail_q  <= tagTail_d;
      if (reqFire) begin
        tag_q[tagTail_q] <= fetchPc_q;
      end
      if (pushEn) begin
        entryPc_q[tail_q]    <= tag_q[tagHead_q];
        entryInstr_q[tail_q] <= bus.imem_resp_data;
      end
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: behavioural in-order memory with
// programmable latency plus a scoreboard of expected {pc, instruction} pairs.
module tb_instruction_fetch;
  localparam logic [31:0] RstPc = 32'h0000_0100;
  localparam int          Depth = 4;

  typedef struct {
    logic [31:0] pc;
    int          due;
    int          epoch;
  } pend_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  int          total = 0;
  int          bad = 0;
  int          memLat;
  int          mcyc = 0;
  int          epoch = 0;
  logic [31:0] expFetch;
  pend_t       pending[$];
  exp_t        expQ[$];

  instruction_fetch_if bus ();

  instruction_fetch #(.RESET_PC(RstPc), .DEPTH(Depth)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memData(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  // Redirect for one cycle, then check the restart in the following cycle.
  task automatic applyStimulus(input logic [31:0] target, input logic readyAfter);
    logic [31:0] aligned;
    aligned            = {target[31:2], 2'b00};
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = target;
    epoch++;
    expFetch = aligned;
    @(negedge clk);
    checkOutput("reqValidInRedirect", 32'(bus.imem_req_valid), 32'd0);
    nextCycle();
    bus.redirect_valid = 1'b0;
    bus.imem_req_ready = readyAfter;
    expQ.delete();
    @(negedge clk);
    checkOutput("validAfterRedirect", 32'(bus.instr_valid), 32'd0);
    checkOutput("reqAfterRedirect", 32'(bus.imem_req_valid), 32'd1);
    checkOutput("addrAfterRedirect", bus.imem_req_addr, aligned);
  endtask

  task automatic waitHead(input logic [31:0] expPc);
    int  n;
    logic seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 30) begin
      @(negedge clk);
      if (bus.instr_valid) seen = 1'b1;
      else n++;
    end
    checkOutput("headArrived", 32'(seen), 32'd1);
    if (seen) begin
      checkOutput("headPc", bus.pc, expPc);
      checkOutput("headPcNext", bus.pcNext, expPc + 32'd4);
    end
  endtask

  // Memory: drives responses just after the edge, samples handshakes mid-cycle.
  initial begin
    pend_t e;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    forever begin
      @(posedge clk);
      mcyc++;
      #1;
      if (!reset_n) begin
        pending.delete();
        bus.imem_resp_valid = 1'b0;
      end else if (pending.size() > 0 && pending[0].due <= mcyc) begin
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = memData(pending[0].pc);
      end else begin
        bus.imem_resp_valid = 1'b0;
      end
      @(negedge clk);
      if (!reset_n) begin
        pending.delete();
      end else begin
        if (bus.imem_resp_valid) begin
          e = pending.pop_front();
          if (e.epoch == epoch && !bus.redirect_valid)
            expQ.push_back('{pc: e.pc, instr: memData(e.pc)});
        end
        if (bus.imem_req_valid && bus.imem_req_ready) begin
          checkOutput("reqAddr", bus.imem_req_addr, expFetch);
          pending.push_back('{pc: expFetch, due: mcyc + memLat, epoch: epoch});
          expFetch = expFetch + 32'd4;
        end
      end
    end
  end

  // Scoreboard: every consumed head must match the oldest expected entry.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (reset_n && bus.instr_valid && bus.instr_ready) begin
        total++;
        assert (expQ.size() > 0) else begin
          bad++;
          $error("[TB] FAIL extraInstr: observed pc=%h expected=none", bus.pc);
        end
        if (expQ.size() > 0) begin
          x = expQ.pop_front();
          checkOutput("sbPc", bus.pc, x.pc);
          checkOutput("sbInstr", bus.instruction, x.instr);
          checkOutput("sbPcNext", bus.pcNext, x.pc + 32'd4);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n            = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    memLat             = 1;
    expFetch           = RstPc;

    nextCycle();
    nextCycle();
    @(negedge clk);
    checkOutput("rstReqValid", 32'(bus.imem_req_valid), 32'd0);
    checkOutput("rstInstrValid", 32'(bus.instr_valid), 32'd0);
    checkOutput("rstInstruction", bus.instruction, 32'd0);
    checkOutput("rstPc", bus.pc, 32'd0);
    checkOutput("rstPcNext", bus.pcNext, 32'd4);

    // Streaming with 1-cycle memory.
    nextCycle();
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("c0ReqValid", 32'(bus.imem_req_valid), 32'd1);
    checkOutput("c0Addr", bus.imem_req_addr, 32'h100);
    checkOutput("c0InstrValid", 32'(bus.instr_valid), 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("c1Addr", bus.imem_req_addr, 32'h104);
    checkOutput("c1InstrValid", 32'(bus.instr_valid), 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("c2Addr", bus.imem_req_addr, 32'h108);
    checkOutput("c2InstrValid", 32'(bus.instr_valid), 32'd1);
    checkOutput("c2Pc", bus.pc, 32'h100);
    checkOutput("c2PcNext", bus.pcNext, 32'h104);
    nextCycle();
    @(negedge clk);
    checkOutput("c3InstrValid", 32'(bus.instr_valid), 32'd1);
    checkOutput("c3Pc", bus.pc, 32'h104);
    repeat (6) nextCycle();

    // Backpressure until the buffer is full, then drain.
    bus.instr_ready = 1'b0;
    repeat (10) nextCycle();
    @(negedge clk);
    checkOutput("fullReqValid", 32'(bus.imem_req_valid), 32'd0);
    checkOutput("fullInstrValid", 32'(bus.instr_valid), 32'd1);
    checkOutput("fullCount", 32'(dut.count_q), 32'(Depth));
    checkOutput("fullInflight", 32'(dut.inflight_q), 32'd0);
    checkOutput("fullSbDepth", 32'(expQ.size()), 32'(Depth));
    nextCycle();
    bus.instr_ready = 1'b1;
    repeat (8) nextCycle();

    // Redirect while two 3-cycle reads are outstanding.
    bus.imem_req_ready = 1'b0;
    memLat             = 3;
    repeat (10) nextCycle();
    @(negedge clk);
    checkOutput("drainedValid", 32'(bus.instr_valid), 32'd0);
    nextCycle();
    bus.imem_req_ready = 1'b1;
    nextCycle();
    nextCycle();
    bus.imem_req_ready = 1'b0;
    checkOutput("twoInflight", 32'(dut.inflight_q), 32'd2);
    applyStimulus(32'h0000_2000, 1'b1);
    checkOutput("twoDiscard", 32'(dut.discard_q), 32'd2);
    waitHead(32'h0000_2000);
    repeat (4) nextCycle();

    // Redirect in the same cycle as the only outstanding response.
    bus.imem_req_ready = 1'b0;
    memLat             = 2;
    repeat (10) nextCycle();
    bus.imem_req_ready = 1'b1;
    nextCycle();
    bus.imem_req_ready = 1'b0;
    nextCycle();
    checkOutput("oneInflight", 32'(dut.inflight_q), 32'd1);
    memLat = 1;
    applyStimulus(32'h0000_0040, 1'b1);
    checkOutput("sameCycleDiscard", 32'(dut.discard_q), 32'd0);
    waitHead(32'h0000_0040);
    repeat (4) nextCycle();

    // Address wrap; low redirect bits are ignored.
    applyStimulus(32'hFFFF_FFFE, 1'b1);
    nextCycle();
    @(negedge clk);
    checkOutput("wrapAddr", bus.imem_req_addr, 32'h0000_0000);
    waitHead(32'hFFFF_FFFC);
    repeat (3) nextCycle();

    // Asynchronous reset while the buffer is full.
    bus.instr_ready = 1'b0;
    repeat (10) nextCycle();
    @(negedge clk);
    checkOutput("preRstFull", 32'(bus.instr_valid), 32'd1);
    nextCycle();
    #1;
    reset_n = 1'b0;
    epoch++;
    expQ.delete();
    expFetch = RstPc;
    #1;
    checkOutput("midRstInstrValid", 32'(bus.instr_valid), 32'd0);
    checkOutput("midRstReqValid", 32'(bus.imem_req_valid), 32'd0);
    checkOutput("midRstPcNext", bus.pcNext, 32'd4);
    nextCycle();
    nextCycle();
    reset_n         = 1'b1;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    checkOutput("postRstReqValid", 32'(bus.imem_req_valid), 32'd1);
    checkOutput("postRstAddr", bus.imem_req_addr, RstPc);
    waitHead(RstPc);
    repeat (8) nextCycle();

    // Stop fetching and confirm everything fetched was delivered.
    bus.imem_req_ready = 1'b0;
    repeat (8) nextCycle();
    @(negedge clk);
    checkOutput("finalInstrValid", 32'(bus.instr_valid), 32'd0);
    checkOutput("finalSbEmpty", 32'(expQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage directly upstream of the single-cycle execute datapath. It owns the program counter, issues word reads to instruction memory over a valid/ready request channel, and buffers in-order responses in a small FIFO. It presents `instruction`, `pc` and `pcNext` to the execute stage with a valid/ready handshake. A redirect input flushes the buffer, discards stale in-flight responses and restarts fetch at a new address.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset; bits [1:0] must be 0.
- `DEPTH`, default 2: FIFO entries and maximum in-flight requests; power of two, 2..8.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `imem_req_valid`  out  1: read request valid.
- `imem_req_ready`  in  1: memory accepts the request this cycle.
- `imem_req_addr`  out  32: word-aligned fetch address.
- `imem_resp_valid`  in  1: read data returning. Responses are in order, at most one per cycle, and arrive no earlier than the cycle after acceptance.
- `imem_resp_data`  in  32: instruction word.
- `redirect_valid`  in  1: restart fetch at `redirect_pc`.
- `redirect_pc`  in  32: new fetch address; bits [1:0] are ignored and treated as 0.
- `instr_valid`  out  1: FIFO head valid.
- `instr_ready`  in  1: execute stage consumes the head.
- `instruction`  out  32: head instruction word.
- `pc`  out  32: address of the head instruction.
- `pcNext`  out  32: `pc + 4`, modulo 2^32.

## Operation
- **State registers:**
  - `fetch_pc` (32 bits).
  - `inflight`: accepted requests without a response, 0..DEPTH.
  - `discard`: in-flight responses to drop, 0..DEPTH.
  - FIFO of {pc, instruction}, plus head pointer, tail pointer and count.
  - Tag FIFO of request addresses, DEPTH entries, pairing each response with its pc.
- **Issue:**
  - `imem_req_valid = !redirect_valid && (inflight + count) < DEPTH`.
  - `imem_req_addr = fetch_pc`.
  - On `imem_req_valid && imem_req_ready`: push `fetch_pc` to the tag FIFO, set `fetch_pc <= fetch_pc + 4` (wraps 0xFFFF_FFFC -> 0), and increment `inflight`.
  - `imem_req_valid` is combinational. Once asserted, it and `imem_req_addr` hold until accepted, unless a redirect arrives.
- **Response:** on `imem_resp_valid`, pop the tag FIFO and decrement `inflight`.
  - If `discard > 0`: decrement `discard` and drop the data.
  - Otherwise push {tag, `imem_resp_data`} into the FIFO.
  - The credit rule guarantees the FIFO is never full on a push.
- **Consume:** on `instr_valid && instr_ready`, pop the head.
  - `instr_valid = (count != 0)`.
  - `instruction` and `pc` come from the head entry; `pcNext = pc + 4`.
  - Outputs are don't-care when invalid but must not be X after reset (FIFO storage resets to 0).
- **Redirect** (highest priority in its cycle):
  - Clear the FIFO (count = 0).
  - Set `fetch_pc <= {redirect_pc[31:2], 2'b00}`.
  - Set `discard <= inflight - (imem_resp_valid ? 1 : 0)`, i.e. all remaining in-flight responses.
  - Issue no request in the redirect cycle.
  - A consume handshake in the same cycle counts as accepted (the jump itself); the rest of the FIFO is flushed.
  - A response arriving in the redirect cycle is always dropped.
- **Simultaneous push and pop** in one cycle: count is unchanged and both pointers advance.
- **Reset** (asynchronous, any time, including mid-transaction):
  - `fetch_pc = RESET_PC`; `inflight`, `discard` and count = 0; pointers = 0.
  - Outputs: `imem_req_valid` is 1 combinationally once `reset_n` is high. During reset, `imem_req_valid = 0`, `instr_valid = 0`, `instruction = 0`, `pc = 0`, `pcNext = 4`.
  - Memory responses for requests issued before reset are the environment's responsibility; the memory is reset together with this block.

## Timing
- First request: in the first cycle after `reset_n` deasserts, `imem_req_addr = RESET_PC`.
- Minimum latency from request acceptance at cycle t:
  - response at t+1;
  - FIFO push at the t+1 edge;
  - `instr_valid` at t+2.
- There is no combinational path from `imem_resp_*` to `instr_*`.
- Throughput: one instruction per cycle with 1-cycle memory latency and DEPTH >= 2.
- Redirect at cycle r: `instr_valid = 0` at r+1, and the first new request is at r+1 with address `redirect_pc`.
- `instr_ready` never affects `imem_req_valid` in the same cycle; credit uses the registered count.

## Test plan
- **Reset and streaming:**
  - Setup: `RESET_PC` = 0x100, memory latency 1, `instr_ready` = 1.
  - Required: requests to 0x100, 0x104, 0x108 on consecutive cycles; `instr_valid` from cycle 2; `pc` = 0x100, `pcNext` = 0x104; one instruction per cycle.
- **Backpressure:**
  - Setup: hold `instr_ready` = 0.
  - Required: after DEPTH responses `imem_req_valid` drops and count = DEPTH. Release `instr_ready` and the entries drain in order with no loss or duplication.
- **Redirect with two in flight:**
  - Setup: 3-cycle memory latency; pulse redirect to 0x2000 while `inflight` = 2.
  - Required: both stale responses are dropped; the next `instr_valid` shows `pc` = 0x2000.
- **Same-cycle redirect and response:**
  - Setup: redirect to 0x40 in the same cycle a response arrives, with `inflight` = 1.
  - Required: the response is dropped, `discard` = 0, next request address = 0x40.
- **Wrap-around:**
  - Setup: redirect to 0xFFFF_FFFC.
  - Required: requests go to 0xFFFF_FFFC then 0x0; the head shows `pcNext` = 0x0.
- **Reset mid-operation:**
  - Setup: assert `reset_n` low asynchronously while the FIFO is full.
  - Required: `instr_valid` = 0 and `imem_req_valid` = 0 immediately; after release, the first request goes to `RESET_PC`.
